// File: rtl/sseg_scan_arbiter.sv
// Four-digit multiplexed seven-segment scan controller: shares the display between a
// background source A and a priority source B, with per-digit blanking and PWM brightness.
module sseg_scan_arbiter #(
    parameter int unsigned SCAN_DIV    = 250000,
    parameter int unsigned HOLD_FRAMES = 100
) (
    input  logic        clk,
    input  logic        greset,
    input  logic [15:0] a_data,
    input  logic [15:0] b_data,
    input  logic        b_req,
    input  logic [3:0]  blank_mask,
    input  logic [2:0]  bright,
    output logic [3:0]  hex_out,
    output logic [3:0]  sseg_anode,
    output logic        owner,
    output logic        frame_tick
);
    localparam int unsigned       SC_W      = $clog2(SCAN_DIV);
    localparam int unsigned       HOLD_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(SCAN_DIV - 1);
    localparam logic [SC_W:0]     ON_UNIT   = (SC_W+1)'(SCAN_DIV / 8);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

    typedef enum logic {
        SHOW_A = 1'b0,
        SHOW_B = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [SC_W-1:0]   sc;
    logic [1:0]        d;
    logic [HOLD_W-1:0] hold, hold_nx;
    logic [15:0]       b_latch, b_latch_nx;
    logic [15:0]       disp_word;
    logic [3:0]        bright_p1;
    logic [SC_W:0]     on_len;
    logic              lit;
    logic              blank;
    logic [3:0]        hex_nx;
    logic [3:0]        anode_nx;

    assign frame_tick = (sc == SC_LAST) && (d == 2'd3);
    assign owner      = (state == SHOW_B);
    assign bright_p1  = {1'b0, bright} + 4'd1;
    assign on_len     = (SC_W+1)'(bright_p1) * ON_UNIT;
    assign lit        = ({1'b0, sc} < on_len);
    assign blank      = blank_mask[2'd3 - d];

    always_ff @(posedge clk or negedge greset) begin
        if (!greset) begin
            sc <= '0;
            d  <= '0;
        end else if (sc == SC_LAST) begin
            sc <= '0;
            d  <= d + 2'd1;
        end else begin
            sc <= sc + SC_W'(1);
        end
    end

    always_comb begin
        state_nx   = state;
        hold_nx    = hold;
        b_latch_nx = b_latch;
        unique case (state)
            SHOW_A: begin
                if (b_req) begin
                    b_latch_nx = b_data;
                    hold_nx    = HOLD_INIT;
                    state_nx   = SHOW_B;
                end
            end
            SHOW_B: begin
                // A new request wins over the frame countdown, even on a frame_tick
                if (b_req) begin
                    b_latch_nx = b_data;
                    hold_nx    = HOLD_INIT;
                end else if (frame_tick) begin
                    if (hold == HOLD_W'(1)) begin
                        hold_nx  = '0;
                        state_nx = SHOW_A;
                    end else begin
                        hold_nx = hold - HOLD_W'(1);
                    end
                end
            end
            default: state_nx = SHOW_A;
        endcase
    end

    always_comb begin
        hex_nx = '0;
        unique case (d)
            2'd0: hex_nx = disp_word[15:12];
            2'd1: hex_nx = disp_word[11:8];
            2'd2: hex_nx = disp_word[7:4];
            2'd3: hex_nx = disp_word[3:0];
            default: hex_nx = '0;
        endcase
        anode_nx = '1;
        if (lit && !blank) begin
            anode_nx = ~(4'b1000 >> d);
        end
    end

    always_ff @(posedge clk or negedge greset) begin
        if (!greset) begin
            state      <= SHOW_A;
            hold       <= '0;
            b_latch    <= '0;
            disp_word  <= '0;
            hex_out    <= '0;
            sseg_anode <= '1;
        end else begin
            state      <= state_nx;
            hold       <= hold_nx;
            b_latch    <= b_latch_nx;
            hex_out    <= hex_nx;
            sseg_anode <= anode_nx;
            // Word only changes at frame boundaries; uses pre-update owner and b_latch
            if (frame_tick) begin
                disp_word <= (state == SHOW_B) ? b_latch : a_data;
            end
        end
    end
endmodule

// File: tb/tb_sseg_scan_arbiter.sv
// Self-checking bench for sseg_scan_arbiter (SCAN_DIV=8, HOLD_FRAMES=2, 32-clock frame)
// using a cycle-position scoreboard for hex_out, sseg_anode, owner and frame_tick.
module tb_sseg_scan_arbiter;
    localparam int unsigned FRAME = 32;

    logic        clk = 1'b0;
    logic        greset;
    logic [15:0] a_data;
    logic [15:0] b_data;
    logic        b_req;
    logic [3:0]  blank_mask;
    logic [2:0]  bright;
    logic [3:0]  hex_out;
    logic [3:0]  sseg_anode;
    logic        owner;
    logic        frame_tick;

    always #5 clk = ~clk;

    sseg_scan_arbiter #(
        .SCAN_DIV   (8),
        .HOLD_FRAMES(2)
    ) dut (
        .clk       (clk),
        .greset    (greset),
        .a_data    (a_data),
        .b_data    (b_data),
        .b_req     (b_req),
        .blank_mask(blank_mask),
        .bright    (bright),
        .hex_out   (hex_out),
        .sseg_anode(sseg_anode),
        .owner     (owner),
        .frame_tick(frame_tick)
    );

    typedef struct packed {
        logic [3:0] hex;
        logic [3:0] an;
        logic       own;
        logic       ft;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned k;              // clock edges since reset release
    logic [15:0] shown_word;     // word the display is currently scanning
    logic [15:0] load_word;      // word expected at the next frame boundary
    logic        exp_owner;      // owner expected after the coming edge

    function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] s);
        case (s)
            2'd0: return w[15:12];
            2'd1: return w[11:8];
            2'd2: return w[7:4];
            default: return w[3:0];
        endcase
    endfunction

    function automatic logic [3:0] exp_anode(input int unsigned pos, input logic [2:0] br,
                                             input logic [3:0] mask);
        logic [1:0]  s   = 2'(pos / 8);
        int unsigned c   = pos % 8;
        logic [3:0]  sel = 4'b1000 >> s;
        if ((mask & sel) != 4'b0000 || c > 32'(br)) return 4'hF;
        return ~sel;
    endfunction

    function automatic bit tick_now();
        return (k % FRAME) == FRAME - 1;
    endfunction

    // Push the expectation for the coming edge, clock once, then drain and compare.
    task automatic step();
        exp_t        e;
        exp_t        g;
        int unsigned pos;
        pos   = k % FRAME;
        e.hex = nib(shown_word, 2'(pos / 8));
        e.an  = exp_anode(pos, bright, blank_mask);
        e.own = exp_owner;
        e.ft  = ((k + 1) % FRAME) == FRAME - 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (pos == FRAME - 1) shown_word = load_word;
        k++;
        g = sb.pop_front();
        total++;
        if (hex_out !== g.hex) begin
            bad++;
            $display("FAIL sb_hex k=%0d got=%h exp=%h", k, hex_out, g.hex);
        end
        total++;
        if (sseg_anode !== g.an) begin
            bad++;
            $display("FAIL sb_anode k=%0d got=%b exp=%b", k, sseg_anode, g.an);
        end
        total++;
        if (owner !== g.own) begin
            bad++;
            $display("FAIL sb_owner k=%0d got=%b exp=%b", k, owner, g.own);
        end
        total++;
        if (frame_tick !== g.ft) begin
            bad++;
            $display("FAIL sb_frame_tick k=%0d got=%b exp=%b", k, frame_tick, g.ft);
        end
    endtask

    task automatic advance_to(input int unsigned pos);
        for (int i = 0; i < 40; i++) begin
            if (k % FRAME == pos) break;
            step();
        end
    endtask

    task automatic test_reset();
        int unsigned ft_cnt;
        greset = 1'b0; a_data = 16'h1234; b_data = '0; b_req = 1'b0;
        blank_mask = 4'b0000; bright = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sseg_anode !== 4'b1111) begin bad++; $display("FAIL rst_anode got=%b exp=1111", sseg_anode); end
        total++;
        if (hex_out !== 4'h0) begin bad++; $display("FAIL rst_hex got=%h exp=0", hex_out); end
        total++;
        if (owner !== 1'b0) begin bad++; $display("FAIL rst_owner got=%b exp=0", owner); end
        total++;
        if (frame_tick !== 1'b0) begin bad++; $display("FAIL rst_frame_tick got=%b exp=0", frame_tick); end
        greset = 1'b1;
        k = 0; shown_word = '0; load_word = 16'h1234; exp_owner = 1'b0;
        step();
        total++;
        if (sseg_anode !== 4'b0111) begin bad++; $display("FAIL first_edge_anode got=%b exp=0111", sseg_anode); end
        ft_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (frame_tick === 1'b1) ft_cnt++;
        end
        total++;
        if (ft_cnt != 2) begin bad++; $display("FAIL frame_tick_rate got=%0d exp=2", ft_cnt); end
    endtask

    task automatic test_digits();
        logic [15:0] want_hex = 16'h1234;
        logic [15:0] want_an  = 16'h7BDE;
        logic [1:0]  s;
        advance_to(0);
        for (int i = 0; i < 32; i++) begin
            step();
            if (i % 8 == 7) begin
                s = 2'(i / 8);
                total++;
                if (hex_out !== nib(want_hex, s)) begin
                    bad++; $display("FAIL digit_hex slot=%0d got=%h exp=%h", s, hex_out, nib(want_hex, s));
                end
                total++;
                if (sseg_anode !== nib(want_an, s)) begin
                    bad++; $display("FAIL digit_anode slot=%0d got=%b exp=%b", s, sseg_anode, nib(want_an, s));
                end
            end
        end
    endtask

    task automatic test_brightness();
        int unsigned lit_cnt;
        bright = 3'd0;
        lit_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (sseg_anode !== 4'b1111) lit_cnt++;
        end
        total++;
        if (lit_cnt != 4) begin bad++; $display("FAIL bright0_lit got=%0d exp=4", lit_cnt); end
        bright = 3'd3;
        lit_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (sseg_anode !== 4'b1111) lit_cnt++;
        end
        total++;
        if (lit_cnt != 16) begin bad++; $display("FAIL bright3_lit got=%0d exp=16", lit_cnt); end
        bright = 3'd7;
    endtask

    task automatic test_blank();
        int unsigned left_dark;
        blank_mask = 4'b1000;
        advance_to(0);
        left_dark = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (i < 8 && sseg_anode === 4'b1111 && hex_out === 4'h1) left_dark++;
        end
        total++;
        if (left_dark != 8) begin bad++; $display("FAIL blank_left got=%0d exp=8", left_dark); end
        blank_mask = 4'b0000;
    endtask

    task automatic test_b_req();
        int unsigned ticks;
        bit          t;
        advance_to(10);
        b_data = 16'hABCD; b_req = 1'b1; exp_owner = 1'b1;
        step();
        b_req = 1'b0; b_data = 16'hFFFF;
        load_word = 16'hABCD;
        total++;
        if (owner !== 1'b1) begin bad++; $display("FAIL breq_owner got=%b exp=1", owner); end
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            t = tick_now();
            if (t) ticks++;
            if (t && ticks == 2) exp_owner = 1'b0;
            step();
            if (t && ticks == 2) load_word = 16'h1234;
        end
        total++;
        if (ticks != 3) begin bad++; $display("FAIL breq_ticks got=%0d exp=3", ticks); end
    endtask

    task automatic test_back_to_back();
        int unsigned ticks;
        bit          t;
        advance_to(10);
        b_data = 16'hABCD; b_req = 1'b1; exp_owner = 1'b1;
        step();
        b_req = 1'b0; b_data = 16'h0000;
        load_word = 16'hABCD;
        ticks = 0;
        for (int i = 0; i < 160; i++) begin
            t = tick_now();
            if (t) ticks++;
            if (t && ticks == 2) begin b_req = 1'b1; b_data = 16'h5678; end
            if (t && ticks == 4) exp_owner = 1'b0;
            step();
            b_req = 1'b0;
            if (t && ticks == 2) load_word = 16'h5678;
            if (t && ticks == 4) load_word = 16'h1234;
            if (t && ticks == 3) begin
                total++;
                if (owner !== 1'b1) begin bad++; $display("FAIL b2b_hold_reload got=%b exp=1", owner); end
            end
        end
        total++;
        if (ticks != 5) begin bad++; $display("FAIL b2b_ticks got=%0d exp=5", ticks); end
    endtask

    task automatic test_async_reset();
        advance_to(5);
        b_data = 16'h0F0F; b_req = 1'b1; exp_owner = 1'b1;
        step();
        b_req = 1'b0;
        load_word = 16'h0F0F;
        for (int i = 0; i < 40; i++) step();
        #2;
        greset = 1'b0;
        #1;
        total++;
        if (owner !== 1'b0) begin bad++; $display("FAIL async_owner got=%b exp=0", owner); end
        total++;
        if (sseg_anode !== 4'b1111) begin bad++; $display("FAIL async_anode got=%b exp=1111", sseg_anode); end
        total++;
        if (hex_out !== 4'h0) begin bad++; $display("FAIL async_hex got=%h exp=0", hex_out); end
        @(posedge clk);
        #1;
        greset = 1'b1;
        k = 0; shown_word = '0; load_word = 16'h1234; exp_owner = 1'b0;
        step();
        total++;
        if (sseg_anode !== 4'b0111) begin bad++; $display("FAIL restart_anode got=%b exp=0111", sseg_anode); end
        for (int i = 0; i < 40; i++) step();
    endtask

    initial begin
        test_reset();
        test_digits();
        test_brightness();
        test_blank();
        test_b_req();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
